tl_sram_slave: RTL

- Single-beat TileLink-UL memory slave sitting directly downstream of the TL fragmenter stage.
- Consumes its output A channel: max 8-byte beats, 2-bit size, 7-bit source, 26-bit address, 64-bit data.
- Returns responses on its D channel from an internal synchronous word-wide SRAM array.
- Gives the fragmented MMIO/scratchpad path a real target with backpressure-correct, 1-cycle-latency responses.

---
 rtl/tl_ul_pkg.sv | 19 +
 rtl/tl_sram_slave_if.sv | 46 ++++
 rtl/sram_1rw_be.sv | 34 +++
 rtl/tl_sram_slave.sv | 110 +++++++++++
 4 files changed

// File: rtl/tl_ul_pkg.sv
// TileLink-UL opcode and width constants shared by the SRAM slave.
// Imported by the bus interface, the slave top and its array.
package tl_ul_pkg;

    localparam int DATA_BITS = 64;
    localparam int MASK_BITS = 8;

    localparam logic [2:0] PUT_FULL    = 3'd0;
    localparam logic [2:0] PUT_PARTIAL = 3'd1;
    localparam logic [2:0] GET         = 3'd4;

    localparam logic [2:0] ACCESS_ACK      = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

    function automatic logic is_put(input logic [2:0] op);
        return (op == PUT_FULL) || (op == PUT_PARTIAL);
    endfunction

endpackage

// File: rtl/tl_sram_slave_if.sv
// A/D channel bundle between the fragmenter (master) and the SRAM slave.
// Signal names mirror the flattened TileLink port names.
interface tl_sram_slave_if
    import tl_ul_pkg::*;
#(
    parameter int ADDR_BITS   = 26,
    parameter int SOURCE_BITS = 7
);

    logic                   in_a_valid;
    logic                   in_a_ready;
    logic [2:0]             in_a_bits_opcode;
    logic [2:0]             in_a_bits_param;
    logic [1:0]             in_a_bits_size;
    logic [SOURCE_BITS-1:0] in_a_bits_source;
    logic [ADDR_BITS-1:0]   in_a_bits_address;
    logic [MASK_BITS-1:0]   in_a_bits_mask;
    logic [DATA_BITS-1:0]   in_a_bits_data;
    logic                   in_a_bits_corrupt;

    logic                   in_d_ready;
    logic                   in_d_valid;
    logic [2:0]             in_d_bits_opcode;
    logic [1:0]             in_d_bits_size;
    logic [SOURCE_BITS-1:0] in_d_bits_source;
    logic [DATA_BITS-1:0]   in_d_bits_data;

    modport master (
        output in_a_valid, in_a_bits_opcode, in_a_bits_param,
        output in_a_bits_size, in_a_bits_source, in_a_bits_address,
        output in_a_bits_mask, in_a_bits_data, in_a_bits_corrupt,
        output in_d_ready,
        input  in_a_ready, in_d_valid, in_d_bits_opcode,
        input  in_d_bits_size, in_d_bits_source, in_d_bits_data
    );

    modport slave (
        input  in_a_valid, in_a_bits_opcode, in_a_bits_param,
        input  in_a_bits_size, in_a_bits_source, in_a_bits_address,
        input  in_a_bits_mask, in_a_bits_data, in_a_bits_corrupt,
        input  in_d_ready,
        output in_a_ready, in_d_valid, in_d_bits_opcode,
        output in_d_bits_size, in_d_bits_source, in_d_bits_data
    );

endinterface

// File: rtl/sram_1rw_be.sv
// Single-port synchronous word array with byte enables, 1-cycle read.
// Read output only changes on a read, so it holds across stalls.
module sram_1rw_be
    import tl_ul_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int INDEX_BITS  = $clog2(DEPTH_WORDS)
) (
    input  logic                  clock,
    input  logic                  en,
    input  logic                  we,
    input  logic [MASK_BITS-1:0]  be,
    input  logic [INDEX_BITS-1:0] addr,
    input  logic [DATA_BITS-1:0]  wdata,
    output logic [DATA_BITS-1:0]  rdata
);

    logic [DATA_BITS-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clock) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < MASK_BITS; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/tl_sram_slave.sv
// Single-beat TileLink-UL memory slave with a one-deep response register.
// in_a_ready is combinational from in_d_ready; no skid buffer.
module tl_sram_slave
    import tl_ul_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_BITS   = 26,
    parameter int SOURCE_BITS = 7
) (
    input  logic            clock,
    input  logic            reset,
    tl_sram_slave_if.slave  bus,
    output logic            err_sticky
);

    localparam int INDEX_BITS = $clog2(DEPTH_WORDS);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]             state;
    logic                   accept;
    logic                   op_put;
    logic                   op_get;
    logic                   op_bad;
    logic                   mem_en;
    logic                   mem_we;
    logic [INDEX_BITS-1:0]  index;
    logic [DATA_BITS-1:0]   rdata;
    logic [2:0]             d_opcode;
    logic [1:0]             d_size;
    logic [SOURCE_BITS-1:0] d_source;
    logic                   d_is_data;
    logic                   unused_bits;

    assign bus.in_d_valid = (state == FULL);
    assign bus.in_a_ready = (state == EMPTY) || bus.in_d_ready;
    assign accept         = bus.in_a_valid && bus.in_a_ready;

    always_comb begin
        op_put = 1'b0;
        op_get = 1'b0;
        op_bad = 1'b0;
        unique case (1'b1)
            is_put(bus.in_a_bits_opcode):  op_put = 1'b1;
            (bus.in_a_bits_opcode == GET): op_get = 1'b1;
            default:                       op_bad = 1'b1;
        endcase
    end

    // Corrupt Puts never reach the array.
    assign mem_en = accept && (op_get || (op_put && !bus.in_a_bits_corrupt));
    assign mem_we = op_put;
    assign index  = bus.in_a_bits_address[INDEX_BITS+2:3];

    assign unused_bits = ^{bus.in_a_bits_param, bus.in_a_bits_address};

    sram_1rw_be #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .INDEX_BITS  (INDEX_BITS)
    ) u_sram (
        .clock (clock),
        .en    (mem_en),
        .we    (mem_we),
        .be    (bus.in_a_bits_mask),
        .addr  (index),
        .wdata (bus.in_a_bits_data),
        .rdata (rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            unique case (state)
                EMPTY:   if (accept) state <= FULL;
                FULL:    if (!accept && bus.in_d_ready) state <= EMPTY;
                default: state <= EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            d_opcode  <= ACCESS_ACK;
            d_size    <= '0;
            d_source  <= '0;
            d_is_data <= 1'b0;
        end else if (accept) begin
            d_opcode  <= op_get ? ACCESS_ACK_DATA : ACCESS_ACK;
            d_size    <= bus.in_a_bits_size;
            d_source  <= bus.in_a_bits_source;
            d_is_data <= op_get;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            err_sticky <= 1'b0;
        end else if (accept && (op_bad || (op_put && bus.in_a_bits_corrupt))) begin
            err_sticky <= 1'b1;
        end
    end

    assign bus.in_d_bits_opcode = d_opcode;
    assign bus.in_d_bits_size   = d_size;
    assign bus.in_d_bits_source = d_source;
    assign bus.in_d_bits_data   = d_is_data ? rdata : '0;

endmodule
